// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART receiver.
// Holds the FSM state enum, default frame constants and the majority-of-3 voter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam int UART_DBIT = 8;
  localparam int UART_OVS  = 16;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous rx pin.
// Both stages reset to 1 so a reset never looks like a start bit.
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic rx,
  output logic rx_s
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= rx;
      sync_q <= meta_q;
    end
  end

  assign rx_s = sync_q;

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver FSMD: oversampled, 3-sample majority vote, false-start rejection.
// Optional parity bit enabled by defining UART_RX_PARITY_EN.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DBIT       = UART_DBIT,
  parameter int OVS        = UART_OVS,
  parameter int SB_TICK    = UART_OVS,
  parameter int PARITY_ODD = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic            s_tick,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            parity_err,
  output logic            frame_err,
  output logic            busy
);

  localparam int SW = $clog2(SB_TICK);
  localparam int NW = $clog2(DBIT);

  if (DBIT < 5 || DBIT > 9 || OVS < 8 || OVS > 32 || (OVS % 2) != 0 ||
      SB_TICK < OVS || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
    $error("uart_rx_param: unsupported parameter combination");
  end

  logic            rx_s;
  uart_state_e     state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic [1:0]      hist_q, hist_d;
  logic            armed_q, armed_d;
  logic            fe_q, fe_d;
  logic            fe_now;
  logic            maj;
  logic            done_q, done_d;
  logic [DBIT-1:0] dout_q, dout_d;
  logic            ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic            pe_q, pe_d;
  logic            perr_q, perr_d;
`endif

  uart_rx_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .rx    (rx),
    .rx_s  (rx_s)
  );

  // Vote over the two previous tick samples plus the current one.
  assign maj = maj3({hist_q, rx_s});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      hist_q  <= 2'b11;
      armed_q <= 1'b1;
      fe_q    <= 1'b0;
      done_q  <= 1'b0;
      dout_q  <= '0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pe_q    <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      hist_q  <= hist_d;
      armed_q <= armed_d;
      fe_q    <= fe_d;
      done_q  <= done_d;
      dout_q  <= dout_d;
      ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
      pe_q    <= pe_d;
      perr_q  <= perr_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    hist_d  = hist_q;
    armed_d = armed_q;
    fe_d    = fe_q;
    fe_now  = fe_q;
    done_d  = 1'b0;
    dout_d  = dout_q;
    ferr_d  = ferr_q;
`ifdef UART_RX_PARITY_EN
    pe_d    = pe_q;
    perr_d  = perr_q;
`endif

    if (s_tick) hist_d = {hist_q[0], rx_s};
    if (rx_s) armed_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (armed_q && !rx_s) begin
          state_d = START;
          s_d     = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_q == SW'(OVS/2 - 1)) begin
            if (!maj) begin
              state_d = DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_q == SW'(OVS - 1)) begin
            b_d = {maj, b_q[DBIT-1:1]};
            s_d = '0;
            if (n_q == NW'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              n_d = n_q + NW'(1);
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (s_tick) begin
          if (s_q == SW'(OVS - 1)) begin
            pe_d    = ((^b_q) ^ maj) != (PARITY_ODD != 0);
            s_d     = '0;
            state_d = STOP;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
`endif
      STOP: begin
        if (s_tick) begin
          // With SB_TICK == OVS the stop sample and completion share one tick.
          if (s_q == SW'(OVS - 1)) fe_now = ~maj;
          fe_d = fe_now;
          if (s_q == SW'(SB_TICK - 1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
            dout_d  = b_q;
            ferr_d  = fe_now;
`ifdef UART_RX_PARITY_EN
            perr_d  = pe_q;
`endif
            if (fe_now) armed_d = 1'b0;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign dout         = dout_q;
  assign rx_done_tick = done_q;
  assign frame_err    = ferr_q;
  assign busy         = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err   = perr_q;
`else
  assign parity_err   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param (DBIT=8, OVS=16, SB_TICK=16).
// One s_tick every 4 clk, so one bit period is 64 clk.
module tb_uart_rx_param;

  localparam int BITCLK = 64;
  localparam int FRAMECLK = 10 * BITCLK;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       s_tick = 1'b0;
  logic [7:0] dout;
  logic       rx_done_tick;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;

  uart_rx_param dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx),
    .s_tick       (s_tick),
    .dout         (dout),
    .rx_done_tick (rx_done_tick),
    .parity_err   (parity_err),
    .frame_err    (frame_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (3) @(negedge clk);
      s_tick = 1'b1;
      @(negedge clk);
      s_tick = 1'b0;
    end
  end

  // Counts high cycles, so a pulse wider than one cycle shows up as an extra frame.
  always @(negedge clk) if (rx_done_tick) done_cnt++;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    rx = 1'b0;
    hold(BITCLK);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      hold(BITCLK);
    end
`ifdef UART_RX_PARITY_EN
    rx = par;
    hold(BITCLK);
`else
    if (par) rx = 1'b1;
`endif
    rx = stop;
    hold(BITCLK);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic [7:0] exp_dout;
    logic       exp_pe;
    logic       exp_fe;
  } vec_t;

  vec_t vecs[6];
  logic pe_on;
  int   c0;

  initial begin
`ifdef UART_RX_PARITY_EN
    pe_on = 1'b1;
`else
    pe_on = 1'b0;
`endif
    // Even parity: error when XOR(data) ^ parity bit is 1.
    vecs[0] = '{8'hA5, 1'b0, 8'hA5, 1'b0,          1'b0};
    vecs[1] = '{8'h3C, 1'b1, 8'h3C, pe_on,         1'b0};
    vecs[2] = '{8'h3C, 1'b0, 8'h3C, 1'b0,          1'b0};
    vecs[3] = '{8'h00, 1'b1, 8'h00, pe_on,         1'b0};
    vecs[4] = '{8'h01, 1'b1, 8'h01, 1'b0,          1'b0};
    vecs[5] = '{8'hFE, 1'b0, 8'hFE, pe_on,         1'b0};

    hold(5);
    check("reset_dout", dout, 0);
    check("reset_done", rx_done_tick, 0);
    check("reset_perr", parity_err, 0);
    check("reset_ferr", frame_err, 0);
    check("reset_busy", busy, 0);
    reset = 1'b0;
    hold(BITCLK);

    for (int i = 0; i < 6; i++) begin
      c0 = done_cnt;
      send_frame(vecs[i].data, vecs[i].par, 1'b1);
      check($sformatf("vec%0d_pulses", i), done_cnt - c0, 1);
      check($sformatf("vec%0d_dout", i), dout, vecs[i].exp_dout);
      check($sformatf("vec%0d_perr", i), parity_err, vecs[i].exp_pe);
      check($sformatf("vec%0d_ferr", i), frame_err, vecs[i].exp_fe);
      check($sformatf("vec%0d_busy", i), busy, 0);
    end

    // False start: 4 ticks low then high.
    c0 = done_cnt;
    rx = 1'b0;
    hold(10);
    check("fs_busy_high", busy, 1);
    hold(6);
    rx = 1'b1;
    hold(32);
    check("fs_busy_low", busy, 0);
    hold(2 * BITCLK);
    check("fs_pulses", done_cnt - c0, 0);
    check("fs_dout", dout, 8'hFE);

    // Framing error, then line held low for three frame times.
    c0 = done_cnt;
    send_frame(8'h55, 1'b0, 1'b0);
    hold(3 * FRAMECLK);
    check("fe_pulses", done_cnt - c0, 1);
    check("fe_dout", dout, 8'h55);
    check("fe_ferr", frame_err, 1);
    check("fe_busy", busy, 0);
    rx = 1'b1;
    hold(2 * BITCLK);
    c0 = done_cnt;
    send_frame(8'h12, 1'b0, 1'b1);
    check("fe_next_pulses", done_cnt - c0, 1);
    check("fe_next_dout", dout, 8'h12);
    check("fe_next_ferr", frame_err, 0);

    // One-tick low glitch at the centre of bit 3 of 0xFF.
    c0 = done_cnt;
    rx = 1'b0;
    hold(BITCLK);
    for (int i = 0; i < 8; i++) begin
      rx = 1'b1;
      if (i == 3) begin
        hold(28);
        rx = 1'b0;
        hold(4);
        rx = 1'b1;
        hold(BITCLK - 32);
      end else begin
        hold(BITCLK);
      end
    end
`ifdef UART_RX_PARITY_EN
    rx = 1'b0;
    hold(BITCLK);
`endif
    rx = 1'b1;
    hold(BITCLK);
    check("gl_pulses", done_cnt - c0, 1);
    check("gl_dout", dout, 8'hFF);

    // Reset during data bit 4, then a clean 0x81 frame.
    c0 = done_cnt;
    rx = 1'b0;
    hold(BITCLK);
    for (int i = 0; i < 4; i++) begin
      rx = (i == 0);
      hold(BITCLK);
    end
    rx = 1'b0;
    hold(30);
    check("rst_busy_before", busy, 1);
    reset = 1'b1;
    hold(3);
    rx = 1'b1;
    hold(2);
    reset = 1'b0;
    hold(2);
    check("rst_dout", dout, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_perr", parity_err, 0);
    check("rst_busy", busy, 0);
    hold(2 * BITCLK);
    check("rst_pulses", done_cnt - c0, 0);
    send_frame(8'h81, 1'b0, 1'b1);
    check("rst_next_pulses", done_cnt - c0, 1);
    check("rst_next_dout", dout, 8'h81);
    check("rst_next_ferr", frame_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
